// File: rtl/penc_stream.sv
// Registered priority encoder with a one-entry valid/ready output stage and active-low enable.
// Optional saturating zero/multi-hot word counter enabled by defining PENC_ERRCNT_EN.
module penc_stream #(
  parameter int WIDTH     = 8,
  parameter int OUT_W     = $clog2(WIDTH),
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             zero,
  output logic             multi,
  output logic [CNT_W-1:0] err_cnt
);

  // Handshake: a word moves on in_valid & in_ready, a result leaves on out_valid & out_ready;
  // in_ready depends only on e_n, the held state and out_ready, never on w or in_valid.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             accept;
  logic             complete;
  logic [OUT_W-1:0] enc_y;
  logic             enc_found;
  logic             enc_zero;
  logic             enc_multi;

  assign out_valid = (state == FULL);
  assign in_ready  = ~e_n & ((state == EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign complete  = out_valid & out_ready;

  always_comb begin
    enc_y     = '0;
    enc_found = 1'b0;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w[i] && !enc_found) begin
          enc_y     = OUT_W'(i);
          enc_found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (w[i] && !enc_found) begin
          enc_y     = OUT_W'(i);
          enc_found = 1'b1;
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign enc_zero  = ~|w;
  assign enc_multi = |(w & (w - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      y     <= '0;
      zero  <= 1'b0;
      multi <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (complete && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        y     <= enc_y;
        zero  <= enc_zero;
        multi <= enc_multi;
      end
    end
  end

`ifdef PENC_ERRCNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept && (enc_zero || enc_multi) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
